// File: rtl/regfile_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_sb_if                                          |
// | Description : Read/write/issue bundle between the decode/writeback   |
// |               stages and the register file with scoreboard.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             busy1;
  logic             busy2;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             issue;
  logic [AW-1:0]    issue_addr;
  logic             any_busy;

  // Pipeline side: drives addresses, write and issue requests.
  modport master (
    output ra1, ra2, we, wa, wd, issue, issue_addr,
    input  rd1, rd2, busy1, busy2, any_busy
  );

  // Register file side.
  modport slave (
    input  ra1, ra2, we, wa, wd, issue, issue_addr,
    output rd1, rd2, busy1, busy2, any_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_sb                                             |
// | Description : DEPTH x WIDTH register file, two combinational read    |
// |               ports, one synchronous write port, and a one-bit-per-  |
// |               register pending-write scoreboard for RAW detection.   |
// |               Optional macro REGFILE_BYPASS_EN adds write-through    |
// |               forwarding from the write port to both read ports.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  regfile_sb_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic             w_wr_ok;
  logic             w_is_ok;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic             w_busy1;
  logic             w_busy2;

  // An address is live when it maps to a real register that is not the
  // hardwired zero; everything else reads 0/not-busy and drops writes.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wr_ok = bus.we    && addr_ok(bus.wa);
  assign w_is_ok = bus.issue && addr_ok(bus.issue_addr);

  // Storage and scoreboard update; the issue assignment comes last so a
  // same-address write+issue leaves the new producer pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.wa]  <= bus.wd;
        r_busy[bus.wa] <= 1'b0;
      end
      if (w_is_ok) begin
        r_busy[bus.issue_addr] <= 1'b1;
      end
    end
  end

  // Combinational read ports, masked to zero for dead addresses.
  always_comb begin
    w_rd1   = '0;
    w_rd2   = '0;
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    if (addr_ok(bus.ra1)) begin
      w_rd1   = r_mem[bus.ra1];
      w_busy1 = r_busy[bus.ra1];
    end
    if (addr_ok(bus.ra2)) begin
      w_rd2   = r_mem[bus.ra2];
      w_busy2 = r_busy[bus.ra2];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; its producer is resolving this cycle,
    // and a same-cycle issue only shows up after the edge.
    if (w_wr_ok && (bus.wa == bus.ra1)) begin
      w_rd1   = bus.wd;
      w_busy1 = 1'b0;
    end
    if (w_wr_ok && (bus.wa == bus.ra2)) begin
      w_rd2   = bus.wd;
      w_busy2 = 1'b0;
    end
`else
    // Read-before-write: same-cycle reads of wa see the old contents.
`endif
  end

  assign bus.rd1      = w_rd1;
  assign bus.rd2      = w_rd2;
  assign bus.busy1    = w_busy1;
  assign bus.busy2    = w_busy2;
  assign bus.any_busy = |r_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_regfile_sb                                          |
// | Description : Directed self-checking bench for regfile_sb; one      |
// |               DEPTH=8/ZERO_REG=1 instance and one DEPTH=6/ZERO_REG=0 |
// |               instance for the invalid-address cases.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_regfile_sb;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  regfile_sb_if #(.WIDTH(16), .DEPTH(8)) if8 ();
  regfile_sb_if #(.WIDTH(16), .DEPTH(6)) if6 ();

  regfile_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(6), .ZERO_REG(0)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (if6.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    if8.we    = 1'b0;
    if8.issue = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    if8.ra1 = '0; if8.ra2 = '0; if8.we = 1'b0; if8.wa = '0; if8.wd = '0;
    if8.issue = 1'b0; if8.issue_addr = '0;
    if6.ra1 = '0; if6.ra2 = '0; if6.we = 1'b0; if6.wa = '0; if6.wd = '0;
    if6.issue = 1'b0; if6.issue_addr = '0;
    tick();
    tick();
    reset = 1'b0;

    // Post-reset state.
    if8.ra1 = 3'd3; if8.ra2 = 3'd5; #1;
    check("rst_rd1", 32'(if8.rd1), 32'h0);
    check("rst_rd2", 32'(if8.rd2), 32'h0);
    check("rst_busy1", 32'(if8.busy1), 32'h0);
    check("rst_busy2", 32'(if8.busy2), 32'h0);
    check("rst_any", 32'(if8.any_busy), 32'h0);

    // Write BEEF to r3; same-cycle read depends on forwarding.
    if8.we = 1'b1; if8.wa = 3'd3; if8.wd = 16'hBEEF; #1;
`ifdef REGFILE_BYPASS_EN
    check("wr3_same", 32'(if8.rd1), 32'hBEEF);
`else
    check("wr3_same", 32'(if8.rd1), 32'h0);
`endif
    tick(); idle8(); #1;
    check("wr3_next", 32'(if8.rd1), 32'hBEEF);

    // Issue r4, then resolve it with a write.
    if8.issue = 1'b1; if8.issue_addr = 3'd4;
    tick(); idle8(); if8.ra2 = 3'd4; #1;
    check("iss4_busy", 32'(if8.busy2), 32'h1);
    check("iss4_any", 32'(if8.any_busy), 32'h1);
    if8.we = 1'b1; if8.wa = 3'd4; if8.wd = 16'h0012; #1;
`ifdef REGFILE_BYPASS_EN
    check("wb4_same_busy", 32'(if8.busy2), 32'h0);
    check("wb4_same_rd", 32'(if8.rd2), 32'h0012);
`else
    check("wb4_same_busy", 32'(if8.busy2), 32'h1);
    check("wb4_same_rd", 32'(if8.rd2), 32'h0);
`endif
    tick(); idle8(); #1;
    check("wb4_busy", 32'(if8.busy2), 32'h0);
    check("wb4_rd", 32'(if8.rd2), 32'h0012);
    check("wb4_any", 32'(if8.any_busy), 32'h0);

    // Write and issue r2 on the same edge: data lands, issue wins.
    if8.we = 1'b1; if8.wa = 3'd2; if8.wd = 16'h00AA;
    if8.issue = 1'b1; if8.issue_addr = 3'd2;
    tick(); idle8(); if8.ra1 = 3'd2; #1;
    check("wi2_rd", 32'(if8.rd1), 32'h00AA);
    check("wi2_busy", 32'(if8.busy1), 32'h1);
    check("wi2_any", 32'(if8.any_busy), 32'h1);
    // Re-issue of a busy register stays 1; one write clears it.
    if8.issue = 1'b1; if8.issue_addr = 3'd2;
    tick(); idle8(); #1;
    check("reiss2_busy", 32'(if8.busy1), 32'h1);
    if8.we = 1'b1; if8.wa = 3'd2; if8.wd = 16'h0055;
    tick(); idle8(); #1;
    check("wb2_busy", 32'(if8.busy1), 32'h0);
    check("wb2_rd", 32'(if8.rd1), 32'h0055);

    // Hardwired zero register ignores write and issue.
    if8.we = 1'b1; if8.wa = 3'd0; if8.wd = 16'hFFFF;
    if8.issue = 1'b1; if8.issue_addr = 3'd0;
    tick(); idle8(); if8.ra1 = 3'd0; #1;
    check("z0_rd", 32'(if8.rd1), 32'h0);
    check("z0_busy", 32'(if8.busy1), 32'h0);
    check("z0_any", 32'(if8.any_busy), 32'h0);

    // Write to one register while issuing another.
    if8.we = 1'b1; if8.wa = 3'd5; if8.wd = 16'h5555;
    if8.issue = 1'b1; if8.issue_addr = 3'd6;
    tick(); idle8(); if8.ra1 = 3'd5; if8.ra2 = 3'd6; #1;
    check("diff_rd5", 32'(if8.rd1), 32'h5555);
    check("diff_busy5", 32'(if8.busy1), 32'h0);
    check("diff_busy6", 32'(if8.busy2), 32'h1);

    // Fill r1..r7 with 0x1111*n, issue r2 and r6.
    for (int n = 1; n < 8; n++) begin
      if8.we = 1'b1; if8.wa = 3'(n); if8.wd = 16'(16'h1111 * n);
      tick();
    end
    idle8();
    if8.issue = 1'b1; if8.issue_addr = 3'd2; tick();
    if8.issue = 1'b1; if8.issue_addr = 3'd6; tick();
    idle8(); if8.ra1 = 3'd7; if8.ra2 = 3'd2; #1;
    check("fill_rd7", 32'(if8.rd1), 32'h7777);
    check("fill_busy2", 32'(if8.busy2), 32'h1);
    if8.ra1 = 3'd6; #1;
    check("fill_busy6", 32'(if8.busy1), 32'h1);
    check("fill_rd6", 32'(if8.rd1), 32'h6666);

    // Reset mid-stream with a write and issue in flight.
    reset = 1'b1;
    if8.we = 1'b1; if8.wa = 3'd1; if8.wd = 16'hABCD;
    if8.issue = 1'b1; if8.issue_addr = 3'd3;
    tick(); reset = 1'b0; idle8();
    for (int i = 0; i < 8; i++) begin
      if8.ra1 = 3'(i); #1;
      check($sformatf("mrst_rd%0d", i), 32'(if8.rd1), 32'h0);
      check($sformatf("mrst_busy%0d", i), 32'(if8.busy1), 32'h0);
    end
    check("mrst_any", 32'(if8.any_busy), 32'h0);

    // DEPTH=6, ZERO_REG=0: address 7 is dead, register 0 is ordinary.
    if6.we = 1'b1; if6.wa = 3'd7; if6.wd = 16'h1234;
    if6.issue = 1'b1; if6.issue_addr = 3'd7;
    tick(); if6.we = 1'b0; if6.issue = 1'b0; if6.ra1 = 3'd7; #1;
    check("d6_rd7", 32'(if6.rd1), 32'h0);
    check("d6_busy7", 32'(if6.busy1), 32'h0);
    check("d6_any", 32'(if6.any_busy), 32'h0);
    if6.we = 1'b1; if6.wa = 3'd0; if6.wd = 16'h0F0F;
    if6.issue = 1'b1; if6.issue_addr = 3'd5;
    tick(); if6.we = 1'b0; if6.issue = 1'b0; if6.ra1 = 3'd0; if6.ra2 = 3'd5; #1;
    check("d6_rd0", 32'(if6.rd1), 32'h0F0F);
    check("d6_busy5", 32'(if6.busy2), 32'h1);
    check("d6_any_set", 32'(if6.any_busy), 32'h1);
    if6.issue = 1'b1; if6.issue_addr = 3'd0;
    tick(); if6.issue = 1'b0; #1;
    check("d6_busy0", 32'(if6.busy1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
